// File: rtl/ysyx_22041752_clint_mh_pkg.sv
// Shared CLINT constants, register-region enum and the byte-merge helper
// used by the multi-hart core-local interruptor.
package ysyx_22041752_clint_mh_pkg;

    localparam logic [63:0] CLINT_BASE_ADDR = 64'h0000_0000_0200_0000;
    localparam logic [63:0] MSIP_OFF        = 64'h0000_0000_0000_0000;
    localparam logic [63:0] MTIMECMP_OFF    = 64'h0000_0000_0000_4000;
    localparam logic [63:0] MTIME_OFF       = 64'h0000_0000_0000_BFF8;
    localparam int          CLINT_MAX_HART  = 8;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_MSIP,
        REG_MTIMECMP,
        REG_MTIME
    } clint_reg_e;

    function automatic logic [63:0] merge_bytes(input logic [63:0] oldVal,
                                                input logic [63:0] newVal,
                                                input logic [7:0]  strb);
        logic [63:0] res;
        res = oldVal;
        for (int b = 0; b < 8; b++) begin
            if (strb[b]) res[8*b +: 8] = newVal[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/ysyx_22041752_clint_tick.sv
// mtime prescaler: counts 0..TICK_DIV-1 and flags the last count as a tick.
module ysyx_22041752_clint_tick #(
    parameter int TICK_DIV = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    // With TICK_DIV=1 LAST is 0, so the counter never leaves 0 and ticks every cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/ysyx_22041752_clint_mh.sv
// Multi-hart CLINT: shared mtime, per-hart mtimecmp and msip, MMIO port with
// single-cycle registered read response.
module ysyx_22041752_clint_mh
    import ysyx_22041752_clint_mh_pkg::*;
#(
    parameter int          NHART    = 1,
    parameter int          TICK_DIV = 1,
    parameter logic [63:0] BASE     = CLINT_BASE_ADDR
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             wen,
    input  logic [63:0]      addr,
    input  logic [63:0]      wdata,
    input  logic [7:0]       wstrb,
    output logic [63:0]      rdata,
    output logic             rdat_v,
    output logic             rerr,
    output logic [NHART-1:0] int_t_o,
    output logic [NHART-1:0] int_s_o
);

    localparam logic [60:0] MSIP_WORD  = MSIP_OFF[63:3];
    localparam logic [60:0] CMP_WORD   = MTIMECMP_OFF[63:3];
    localparam logic [60:0] MTIME_WORD = MTIME_OFF[63:3];
    localparam logic [60:0] MSIP_WORDS = 61'((NHART + 1) / 2);
    localparam logic [60:0] CMP_WORDS  = 61'(NHART);

    logic [63:0]               r_mtime;
    logic [63:0]               r_rdata;
    logic                      r_rdatV;
    logic                      r_rerr;
    logic                      w_tick;
    logic                      w_wr;
    logic [63:0]               w_off;
    logic [60:0]               w_word;
    logic [60:0]               w_cmpWord;
    logic [60:0]               w_msipWord;
    clint_reg_e                w_reg;
    logic [2:0]                w_idx;
    logic [63:0]               w_rval;
    logic [63:0]               w_merged;
    logic [63:0]               w_cmpPad [CLINT_MAX_HART];
    logic [CLINT_MAX_HART-1:0] w_msipPad;
    logic                      w_unused;

    ysyx_22041752_clint_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .o_tick  (w_tick)
    );

    // Offsets below a region's start wrap to huge values, so one upper bound per region suffices.
    assign w_off      = {addr[63:3], 3'b000} - BASE;
    assign w_word     = w_off[63:3];
    assign w_cmpWord  = w_word - CMP_WORD;
    assign w_msipWord = w_word - MSIP_WORD;
    assign w_wr       = en & wen;
    assign w_unused   = ^{w_off[2:0], w_cmpWord[60:3], w_msipWord[60:3]};

    always_comb begin
        w_reg = REG_NONE;
        w_idx = '0;
        if (w_word == MTIME_WORD) begin
            w_reg = REG_MTIME;
        end else if (w_cmpWord < CMP_WORDS) begin
            w_reg = REG_MTIMECMP;
            w_idx = w_cmpWord[2:0];
        end else if (w_msipWord < MSIP_WORDS) begin
            w_reg = REG_MSIP;
            w_idx = w_msipWord[2:0];
        end
    end

    // The read mux doubles as the "old" value for byte-masked writes.
    always_comb begin
        w_rval = '0;
        case (w_reg)
            REG_MTIME:    w_rval = r_mtime;
            REG_MTIMECMP: w_rval = w_cmpPad[w_idx];
            REG_MSIP:     w_rval = {31'b0, w_msipPad[{w_idx[1:0], 1'b1}],
                                    31'b0, w_msipPad[{w_idx[1:0], 1'b0}]};
            default:      w_rval = '0;
        endcase
    end

    assign w_merged = merge_bytes(w_rval, wdata, wstrb);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mtime <= '0;
        end else if (w_wr && (w_reg == REG_MTIME)) begin
            r_mtime <= w_merged;
        end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
        end
    end

    // Slots beyond NHART read as zero so the mux never indexes a missing hart.
    for (genvar h = 0; h < CLINT_MAX_HART; h++) begin : g_hart
        if (h < NHART) begin : g_real
            logic [63:0] r_cmp;
            logic        r_msip;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_cmp <= '1;
                end else if (w_wr && (w_reg == REG_MTIMECMP) && (w_idx == 3'(h))) begin
                    r_cmp <= w_merged;
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_msip <= 1'b0;
                end else if (w_wr && (w_reg == REG_MSIP) && (w_idx[1:0] == 2'(h / 2))) begin
                    r_msip <= w_merged[32 * (h % 2)];
                end
            end

            assign w_cmpPad[h]  = r_cmp;
            assign w_msipPad[h] = r_msip;
            assign int_t_o[h]   = (r_mtime >= r_cmp);
            assign int_s_o[h]   = r_msip;
        end else begin : g_pad
            assign w_cmpPad[h]  = '0;
            assign w_msipPad[h] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= '0;
            r_rdatV <= 1'b0;
            r_rerr  <= 1'b0;
        end else if (en && !wen) begin
            r_rdata <= w_rval;
            r_rdatV <= 1'b1;
            r_rerr  <= (w_reg == REG_NONE);
        end else begin
            r_rdatV <= 1'b0;
            r_rerr  <= 1'b0;
        end
    end

    assign rdata  = r_rdata;
    assign rdat_v = r_rdatV;
    assign rerr   = r_rerr;

endmodule

// File: tb/tb_ysyx_22041752_clint_mh.sv
// Self-checking bench for the multi-hart CLINT: directed scenarios plus random
// MMIO traffic against an address-map level reference model.
module tb_ysyx_22041752_clint_mh;

    localparam int          NH   = 4;
    localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;
    localparam logic [63:0] OFF_MTIME = 64'hBFF8;
    localparam logic [63:0] OFF_CMP   = 64'h4000;

    logic          clk;
    logic          reset_n;
    logic          en;
    logic          wen;
    logic [63:0]   addr;
    logic [63:0]   wdata;
    logic [7:0]    wstrb;
    logic [63:0]   rdata;
    logic          rdatV;
    logic          rerr;
    logic [NH-1:0] intT;
    logic [NH-1:0] intS;

    logic          bReset_n;
    logic          bEn;
    logic [63:0]   bAddr;
    logic [63:0]   bWdata;
    logic [7:0]    bWstrb;
    logic          bWen;
    logic [63:0]   bRdata;
    logic          bRdatV;
    logic          bRerr;
    logic [0:0]    bIntT;
    logic [0:0]    bIntS;
    logic          bDone;

    int checks;
    int errors;

    logic [63:0] mMtime;
    logic [63:0] mCmp [NH];
    bit          mMsip [NH];
    logic [63:0] expRdata;

    ysyx_22041752_clint_mh #(
        .NHART    (NH),
        .TICK_DIV (1),
        .BASE     (BASE)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .wen     (wen),
        .addr    (addr),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .rdata   (rdata),
        .rdat_v  (rdatV),
        .rerr    (rerr),
        .int_t_o (intT),
        .int_s_o (intS)
    );

    ysyx_22041752_clint_mh #(
        .NHART    (1),
        .TICK_DIV (4),
        .BASE     (BASE)
    ) dutDiv (
        .clk     (clk),
        .reset_n (bReset_n),
        .en      (bEn),
        .wen     (bWen),
        .addr    (bAddr),
        .wdata   (bWdata),
        .wstrb   (bWstrb),
        .rdata   (bRdata),
        .rdat_v  (bRdatV),
        .rerr    (bRerr),
        .int_t_o (bIntT),
        .int_s_o (bIntS)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        mMtime   = '0;
        expRdata = '0;
        for (int h = 0; h < NH; h++) begin
            mCmp[h]  = '1;
            mMsip[h] = 1'b0;
        end
    endtask

    // Model works on byte offsets from BASE: low three address bits are ignored.
    task automatic modelLookup(input logic [63:0] a, output bit hit, output logic [63:0] val);
        logic [63:0] off;
        int          k;
        off = (a & ~64'h7) - BASE;
        hit = 1'b1;
        val = '0;
        if (off == OFF_MTIME) begin
            val = mMtime;
        end else if (off >= OFF_CMP && off < OFF_CMP + 64'(8 * NH)) begin
            val = mCmp[int'((off - OFF_CMP) / 64'd8)];
        end else if (off < 64'(8 * ((NH + 1) / 2))) begin
            k = int'(off / 64'd8);
            val[0] = mMsip[2 * k];
            if (2 * k + 1 < NH) val[32] = mMsip[2 * k + 1];
        end else begin
            hit = 1'b0;
        end
    endtask

    task automatic modelWrite(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                              output bit mtimeWritten);
        logic [63:0] off;
        logic [63:0] mask;
        int          k;
        off = (a & ~64'h7) - BASE;
        mask = '0;
        for (int b = 0; b < 8; b++) begin
            if (s[b]) mask = mask | (64'hFF << (8 * b));
        end
        mtimeWritten = 1'b0;
        if (off == OFF_MTIME) begin
            mMtime = (mMtime & ~mask) | (d & mask);
            mtimeWritten = 1'b1;
        end else if (off >= OFF_CMP && off < OFF_CMP + 64'(8 * NH)) begin
            k = int'((off - OFF_CMP) / 64'd8);
            mCmp[k] = (mCmp[k] & ~mask) | (d & mask);
        end else if (off < 64'(8 * ((NH + 1) / 2))) begin
            k = int'(off / 64'd8);
            if (s[0]) mMsip[2 * k] = d[0];
            if (s[4] && (2 * k + 1 < NH)) mMsip[2 * k + 1] = d[32];
        end
    endtask

    // One bus cycle: drive at negedge, advance the model, check just after the posedge.
    task automatic applyStimulus(input bit e, input bit w, input logic [63:0] a,
                                 input logic [63:0] d, input logic [7:0] s);
        bit            hit;
        bit            mtimeWritten;
        logic [63:0]   val;
        bit            expV;
        bit            expErr;
        logic [NH-1:0] expT;
        logic [NH-1:0] expS;
        @(negedge clk);
        en    = e;
        wen   = w;
        addr  = a;
        wdata = d;
        wstrb = s;
        modelLookup(a, hit, val);
        expV   = e && !w;
        expErr = e && !w && !hit;
        if (expV) expRdata = hit ? val : 64'd0;
        mtimeWritten = 1'b0;
        if (e && w) modelWrite(a, d, s, mtimeWritten);
        if (!mtimeWritten) mMtime = mMtime + 64'd1;
        @(posedge clk);
        #1;
        for (int h = 0; h < NH; h++) begin
            expT[h] = (mMtime >= mCmp[h]);
            expS[h] = mMsip[h];
        end
        checkOutput("rdatV", 64'(rdatV), 64'(expV));
        checkOutput("rerr", 64'(rerr), 64'(expErr));
        checkOutput("rdata", rdata, expRdata);
        checkOutput("intT", 64'(intT), 64'(expT));
        checkOutput("intS", 64'(intS), 64'(expS));
    endtask

    task automatic writeReg(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
        applyStimulus(1'b1, 1'b1, a, d, s);
    endtask

    task automatic readReg(input logic [63:0] a);
        applyStimulus(1'b1, 1'b0, a, 64'd0, 8'h00);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 8'h00);
    endtask

    // Prescaled instance: a read at the k-th edge after release sees (k-1)/4.
    initial begin
        logic [63:0] firstVal;
        bDone    = 1'b0;
        bReset_n = 1'b0;
        bEn      = 1'b0;
        bWen     = 1'b0;
        bAddr    = BASE + OFF_MTIME;
        bWdata   = '0;
        bWstrb   = '0;
        firstVal = '0;
        repeat (2) @(negedge clk);
        bReset_n = 1'b1;
        bEn      = 1'b1;
        for (int k = 1; k <= 44; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("presc%0d", k), bRdata, 64'((k - 1) / 4));
            checkOutput("prescRdatV", 64'(bRdatV), 64'd1);
            if (k == 1) firstVal = bRdata;
            if (k == 41) checkOutput("presc40Cycles", bRdata - firstVal, 64'd10);
        end
        @(negedge clk);
        bEn   = 1'b0;
        bDone = 1'b1;
    end

    initial begin
        logic [63:0] offs [12];
        logic [63:0] ra;
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        en      = 1'b0;
        wen     = 1'b0;
        addr    = '0;
        wdata   = '0;
        wstrb   = '0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetIntT", 64'(intT), 64'd0);
        checkOutput("resetIntS", 64'(intS), 64'd0);
        checkOutput("resetRdatV", 64'(rdatV), 64'd0);
        checkOutput("resetRerr", 64'(rerr), 64'd0);
        checkOutput("resetRdata", rdata, 64'd0);
        reset_n = 1'b1;

        idle();
        idle();
        readReg(BASE + OFF_MTIME);
        checkOutput("resetMtime", rdata, 64'd2);
        checkOutput("resetReadValid", 64'(rdatV), 64'd1);

        // Timer on hart 2
        writeReg(BASE + OFF_CMP + 64'h10, 64'd100, 8'hFF);
        for (int i = 0; i < 200 && mMtime < 64'd100; i++) idle();
        checkOutput("timerFire", 64'(intT), 64'b0100);
        writeReg(BASE + OFF_CMP + 64'h10, '1, 8'hFF);
        checkOutput("timerClear", 64'(intT), 64'd0);

        // Software interrupts and MSIP lane layout
        writeReg(BASE, 64'h0000_0001_0000_0001, 8'hFF);
        checkOutput("msipPair0", 64'(intS), 64'b0011);
        writeReg(BASE + 64'h8, 64'd1, 8'h0F);
        checkOutput("msipLowLane", 64'(intS), 64'b0111);
        writeReg(BASE, '1, 8'hFF);
        readReg(BASE);
        checkOutput("msipUpperZero", rdata, 64'h0000_0001_0000_0001);
        readReg(BASE + 64'h8);
        checkOutput("msipWord1", rdata, 64'h0000_0000_0000_0001);

        // Byte strobes on mtime and wraparound
        writeReg(BASE + OFF_MTIME, 64'h1234, 8'hFF);
        writeReg(BASE + OFF_MTIME, 64'hFF00, 8'h02);
        readReg(BASE + OFF_MTIME);
        checkOutput("strobeMerge", rdata, 64'hFF34);
        writeReg(BASE + OFF_MTIME, '1, 8'hFF);
        readReg(BASE + OFF_MTIME);
        checkOutput("wrapPre", rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        readReg(BASE + OFF_MTIME);
        checkOutput("wrapPost", rdata, 64'd0);

        // Unmapped accesses
        readReg(BASE + 64'h8000);
        checkOutput("unmappedRdatV", 64'(rdatV), 64'd1);
        checkOutput("unmappedRerr", 64'(rerr), 64'd1);
        checkOutput("unmappedRdata", rdata, 64'd0);
        writeReg(BASE + 64'h7000, 64'd5, 8'hFF);
        writeReg(BASE + 64'h10, 64'd0, 8'hFF);
        checkOutput("unmappedMsip", 64'(intS), 64'b0111);
        readReg(BASE + OFF_CMP);
        checkOutput("unmappedCmp0", rdata, 64'hFFFF_FFFF_FFFF_FFFF);

        // Random traffic over mapped and unmapped words
        offs = '{64'h0, 64'h8, 64'h10, 64'h4000, 64'h4008, 64'h4010, 64'h4018,
                 64'h4020, 64'hBFF8, 64'h8000, 64'h7000, 64'hBFF0};
        for (int i = 0; i < 400; i++) begin
            ra = BASE + offs[$urandom_range(0, 11)] + 64'($urandom_range(0, 7));
            applyStimulus(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, ra,
                          {$urandom, $urandom}, 8'($urandom));
        end

        // Reset asserted while a read is in flight drops the response
        @(negedge clk);
        en    = 1'b1;
        wen   = 1'b0;
        addr  = BASE + OFF_MTIME;
        #2;
        reset_n = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        checkOutput("midResetRdatV", 64'(rdatV), 64'd0);
        checkOutput("midResetRerr", 64'(rerr), 64'd0);
        checkOutput("midResetRdata", rdata, 64'd0);
        checkOutput("midResetIntS", 64'(intS), 64'd0);
        reset_n = 1'b1;
        idle();
        readReg(BASE + OFF_MTIME);
        checkOutput("recoverMtime", rdata, 64'd1);

        for (int i = 0; i < 1000 && !bDone; i++) @(posedge clk);
        checkOutput("prescDone", 64'(bDone), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
